// File: rtl/sdio_data_pkg.sv
// sdio_data_pkg: shared state/status encodings and limits for the SDIO data sequencer.
package sdio_data_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVE,
        S_GAP,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        ST_OK      = 3'd0,
        ST_CRC     = 3'd1,
        ST_TIMEOUT = 3'd2,
        ST_ABORT   = 3'd3,
        ST_PARAM   = 3'd4
    } status_t;

    localparam int SDIO_MAX_BLOCK_SIZE = 512;

    // Byte-mode count of 0 encodes a full 512-byte transfer.
    function automatic logic [9:0] byte_len(input logic [8:0] count);
        return (count == 9'd0) ? 10'(SDIO_MAX_BLOCK_SIZE) : {1'b0, count};
    endfunction

endpackage

// File: rtl/sdio_seq_timer.sv
// sdio_seq_timer: loadable down-counter; expire_o is high during the last counted cycle.
module sdio_seq_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/sdio_data_sequencer.sv
// sdio_data_sequencer: splits a CMD53 transfer into per-block SDIO data PHY activations.
// Optional per-block watchdog enabled by defining SDIO_DATA_SEQ_TIMEOUT_EN.
module sdio_data_sequencer
    import sdio_data_pkg::*;
#(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_xfer_stb,
    input  logic       i_xfer_write,
    input  logic       i_xfer_block_mode,
    input  logic [8:0] i_xfer_count,
    input  logic [9:0] i_block_size,
    input  logic       i_abort,
    output logic       o_xfer_busy,
    output logic       o_xfer_done,
    output logic [2:0] o_xfer_status,
    output logic [8:0] o_block_index,
    output logic       o_phy_activate,
    output logic       o_phy_write_flag,
    output logic [9:0] o_phy_data_count,
    input  logic       i_phy_done,
    input  logic       i_phy_crc_err
);

    localparam int TMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic        block_mode_q, block_mode_d;
    logic        infinite_q, infinite_d;
    logic [8:0]  count_q, count_d;
    logic [8:0]  remaining_q, remaining_d;
    logic [8:0]  index_q, index_d;
    logic [9:0]  data_count_q, data_count_d;
    logic [2:0]  status_q, status_d;
    logic        tmr_load, tmr_expire;
    logic [TW-1:0] tmr_val;

    sdio_seq_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        block_mode_d = block_mode_q;
        infinite_d   = infinite_q;
        count_d      = count_q;
        remaining_d  = remaining_q;
        index_d      = index_q;
        data_count_d = data_count_q;
        status_d     = status_q;
        tmr_load     = 1'b0;
        tmr_val      = TW'(GAP_CYCLES);
        // Abort outranks every other event, including a coincident PHY done.
        if (i_abort && state_q != S_IDLE && state_q != S_DONE) begin
            state_d  = S_DONE;
            status_d = ST_ABORT;
        end else begin
            case (state_q)
                S_IDLE: if (i_xfer_stb) begin
                    state_d      = S_SETUP;
                    write_d      = i_xfer_write;
                    block_mode_d = i_xfer_block_mode;
                    count_d      = i_xfer_count;
                    remaining_d  = i_xfer_block_mode ? i_xfer_count : 9'd1;
                    infinite_d   = i_xfer_block_mode && (i_xfer_count == 9'd0);
                    index_d      = '0;
                end
                S_SETUP: if (block_mode_q && (i_block_size == '0 || i_block_size > 10'(SDIO_MAX_BLOCK_SIZE))) begin
                    state_d  = S_DONE;
                    status_d = ST_PARAM;
                end else begin
                    state_d      = S_ACTIVE;
                    data_count_d = block_mode_q ? i_block_size : byte_len(count_q);
`ifdef SDIO_DATA_SEQ_TIMEOUT_EN
                    tmr_load     = 1'b1;
                    tmr_val      = TW'(TIMEOUT_CYCLES);
`endif
                end
                S_ACTIVE: if (i_phy_done && write_q && i_phy_crc_err) begin
                    state_d  = S_DONE;
                    status_d = ST_CRC;
                end else if (i_phy_done) begin
                    state_d     = S_GAP;
                    tmr_load    = 1'b1;
                    remaining_d = infinite_q ? remaining_q : remaining_q - 9'd1;
                    index_d     = index_q + 9'd1;
                end
`ifdef SDIO_DATA_SEQ_TIMEOUT_EN
                else if (tmr_expire) begin
                    state_d  = S_DONE;
                    status_d = ST_TIMEOUT;
                end
`endif
                S_GAP: if (tmr_expire) begin
                    state_d  = (!infinite_q && remaining_q == '0) ? S_DONE : S_SETUP;
                    status_d = ST_OK;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            block_mode_q <= 1'b0;
            infinite_q   <= 1'b0;
            count_q      <= '0;
            remaining_q  <= '0;
            index_q      <= '0;
            data_count_q <= '0;
            status_q     <= ST_OK;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            block_mode_q <= block_mode_d;
            infinite_q   <= infinite_d;
            count_q      <= count_d;
            remaining_q  <= remaining_d;
            index_q      <= index_d;
            data_count_q <= data_count_d;
            status_q     <= status_d;
        end
    end

    assign o_xfer_busy      = (state_q != S_IDLE);
    assign o_xfer_done      = (state_q == S_DONE);
    assign o_xfer_status    = status_q;
    assign o_block_index    = index_q;
    assign o_phy_activate   = (state_q == S_ACTIVE);
    assign o_phy_write_flag = write_q;
    assign o_phy_data_count = data_count_q;

endmodule

// File: tb/tb_sdio_data_sequencer.sv
// tb_sdio_data_sequencer: directed self-checking bench for sdio_data_sequencer (GAP_CYCLES=2).
module tb_sdio_data_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_xfer_stb = 1'b0;
    logic       i_xfer_write = 1'b0;
    logic       i_xfer_block_mode = 1'b0;
    logic [8:0] i_xfer_count = '0;
    logic [9:0] i_block_size = '0;
    logic       i_abort = 1'b0;
    logic       i_phy_done = 1'b0;
    logic       i_phy_crc_err = 1'b0;
    logic       o_xfer_busy, o_xfer_done, o_phy_activate, o_phy_write_flag;
    logic [2:0] o_xfer_status;
    logic [8:0] o_block_index;
    logic [9:0] o_phy_data_count;

    int checks = 0;
    int errors = 0;
    int n;

    sdio_data_sequencer #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(100)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_xfer_stb       (i_xfer_stb),
        .i_xfer_write     (i_xfer_write),
        .i_xfer_block_mode(i_xfer_block_mode),
        .i_xfer_count     (i_xfer_count),
        .i_block_size     (i_block_size),
        .i_abort          (i_abort),
        .o_xfer_busy      (o_xfer_busy),
        .o_xfer_done      (o_xfer_done),
        .o_xfer_status    (o_xfer_status),
        .o_block_index    (o_block_index),
        .o_phy_activate   (o_phy_activate),
        .o_phy_write_flag (o_phy_write_flag),
        .o_phy_data_count (o_phy_data_count),
        .i_phy_done       (i_phy_done),
        .i_phy_crc_err    (i_phy_crc_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start(input logic wr, input logic bm, input logic [8:0] cnt, input logic [9:0] bs);
        i_xfer_write = wr;
        i_xfer_block_mode = bm;
        i_xfer_count = cnt;
        i_block_size = bs;
        i_xfer_stb = 1'b1;
        tick();
        i_xfer_stb = 1'b0;
    endtask

    task automatic wait_active(output int cyc);
        cyc = 0;
        while (!o_phy_activate && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("activate_seen", o_phy_activate, 1);
    endtask

    task automatic pulse_done(input logic crc);
        i_phy_done = 1'b1;
        i_phy_crc_err = crc;
        tick();
        i_phy_done = 1'b0;
        i_phy_crc_err = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, o_xfer_busy, 0);
        chk({tag, "_done"}, o_xfer_done, 0);
        chk({tag, "_status"}, o_xfer_status, 0);
        chk({tag, "_index"}, o_block_index, 0);
        chk({tag, "_act"}, o_phy_activate, 0);
        chk({tag, "_wflag"}, o_phy_write_flag, 0);
        chk({tag, "_dcount"}, o_phy_data_count, 0);
    endtask

    initial begin
        #2;
        check_idle_outputs("reset");
        tick();
        rst = 1'b1;
        tick();

        // Abort in IDLE does nothing.
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("idle_abort_busy", o_xfer_busy, 0);
        chk("idle_abort_done", o_xfer_done, 0);

        // Byte-mode read, count 16.
        start(1'b0, 1'b0, 9'd16, 10'd0);
        chk("b16_setup_busy", o_xfer_busy, 1);
        chk("b16_setup_act", o_phy_activate, 0);
        wait_active(n);
        chk("b16_latency", n, 1);
        chk("b16_wflag", o_phy_write_flag, 0);
        chk("b16_dcount", o_phy_data_count, 16);
        chk("b16_index0", o_block_index, 0);
        pulse_done(1'b0);
        chk("b16_act_drop", o_phy_activate, 0);
        chk("b16_gap_done", o_xfer_done, 0);
        tick();
        chk("b16_gap2_done", o_xfer_done, 0);
        tick();
        chk("b16_done", o_xfer_done, 1);
        chk("b16_status", o_xfer_status, 0);
        chk("b16_index1", o_block_index, 1);
        chk("b16_busy_in_done", o_xfer_busy, 1);
        tick();
        chk("b16_busy_after", o_xfer_busy, 0);
        chk("b16_done_after", o_xfer_done, 0);

        // Byte-mode write, count 0 means 512 bytes.
        start(1'b1, 1'b0, 9'd0, 10'd0);
        wait_active(n);
        chk("b512_wflag", o_phy_write_flag, 1);
        chk("b512_dcount", o_phy_data_count, 512);
        pulse_done(1'b0);
        tick();
        tick();
        chk("b512_done", o_xfer_done, 1);
        chk("b512_status", o_xfer_status, 0);
        tick();

        // Block write, 3 x 64 bytes, with a strobe while busy that must be ignored.
        start(1'b1, 1'b1, 9'd3, 10'd64);
        for (int b = 0; b < 3; b++) begin
            wait_active(n);
            if (b > 0) chk("blk3_gap_low", n, 3);
            chk("blk3_dcount", o_phy_data_count, 64);
            chk("blk3_wflag", o_phy_write_flag, 1);
            chk("blk3_index", o_block_index, b);
            if (b == 1) begin
                i_xfer_stb = 1'b1;
                i_xfer_write = 1'b0;
                i_xfer_count = 9'd1;
                tick();
                i_xfer_stb = 1'b0;
                chk("blk3_stb_ignored_wflag", o_phy_write_flag, 1);
                chk("blk3_stb_ignored_act", o_phy_activate, 1);
            end
            pulse_done(1'b0);
        end
        tick();
        tick();
        chk("blk3_done", o_xfer_done, 1);
        chk("blk3_status", o_xfer_status, 0);
        chk("blk3_index", o_block_index, 3);
        tick();

        // Block write, count 4, CRC error on the second block.
        start(1'b1, 1'b1, 9'd4, 10'd64);
        wait_active(n);
        pulse_done(1'b0);
        wait_active(n);
        chk("crc_index_before", o_block_index, 1);
        pulse_done(1'b1);
        chk("crc_done", o_xfer_done, 1);
        chk("crc_status", o_xfer_status, 1);
        chk("crc_index", o_block_index, 1);
        chk("crc_act", o_phy_activate, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_phy_activate) n++;
        end
        chk("crc_no_more_act", n, 0);
        chk("crc_busy_after", o_xfer_busy, 0);

        // Infinite block read, 512-byte blocks; read CRC flag is ignored.
        start(1'b0, 1'b1, 9'd0, 10'd512);
        for (int b = 0; b < 600; b++) begin
            wait_active(n);
            pulse_done(b == 5);
        end
        wait_active(n);
        chk("inf_index_wrap", o_block_index, 88);
        chk("inf_dcount", o_phy_data_count, 512);
        chk("inf_busy", o_xfer_busy, 1);
        i_abort = 1'b1;
        i_phy_done = 1'b1;
        tick();
        i_abort = 1'b0;
        i_phy_done = 1'b0;
        chk("inf_abort_act", o_phy_activate, 0);
        chk("inf_abort_done", o_xfer_done, 1);
        chk("inf_abort_status", o_xfer_status, 3);
        chk("inf_abort_index", o_block_index, 88);
        tick();
        chk("inf_busy_after", o_xfer_busy, 0);

        // Illegal block sizes: 0 and 513.
        start(1'b0, 1'b1, 9'd2, 10'd0);
        chk("bs0_setup_act", o_phy_activate, 0);
        tick();
        chk("bs0_done", o_xfer_done, 1);
        chk("bs0_status", o_xfer_status, 4);
        chk("bs0_act", o_phy_activate, 0);
        tick();
        start(1'b0, 1'b1, 9'd2, 10'd513);
        tick();
        chk("bs513_done", o_xfer_done, 1);
        chk("bs513_status", o_xfer_status, 4);
        chk("bs513_act", o_phy_activate, 0);
        tick();

        // Abort during GAP.
        start(1'b1, 1'b1, 9'd5, 10'd8);
        wait_active(n);
        pulse_done(1'b0);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("gap_abort_done", o_xfer_done, 1);
        chk("gap_abort_status", o_xfer_status, 3);
        tick();

`ifdef SDIO_DATA_SEQ_TIMEOUT_EN
        // Watchdog: 100 ACTIVE cycles with no PHY done.
        start(1'b0, 1'b1, 9'd1, 10'd16);
        wait_active(n);
        n = 0;
        while (o_phy_activate && n < 200) begin
            tick();
            n++;
        end
        chk("tmo_active_cycles", n, 100);
        chk("tmo_done", o_xfer_done, 1);
        chk("tmo_status", o_xfer_status, 2);
        tick();
`endif

        // Asynchronous reset in the middle of ACTIVE.
        start(1'b1, 1'b0, 9'd8, 10'd0);
        wait_active(n);
        chk("rst_pre_act", o_phy_activate, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_busy", o_xfer_busy, 0);
        chk("rst_async_act", o_phy_activate, 0);
        chk("rst_async_wflag", o_phy_write_flag, 0);
        chk("rst_async_dcount", o_phy_data_count, 0);
        chk("rst_async_index", o_block_index, 0);
        chk("rst_async_done", o_xfer_done, 0);
        chk("rst_async_status", o_xfer_status, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_release_busy", o_xfer_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
